// File: rtl/mvm_result_serializer.sv
// Row serializer for the matrix-vector multiplier: one packed result word in,
// m_rows tagged rows out, with a one-word pending buffer to decouple the multiplier.
module mvm_result_serializer #(
  parameter int data_width = 2,
  parameter int n_columns  = 2,
  parameter int m_rows     = 2,
  parameter int res_width  = 2*data_width + $clog2(n_columns) + 1,
  parameter int row_w      = (m_rows > 1) ? $clog2(m_rows) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [m_rows*res_width-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [res_width-1:0]        out_data,
  output logic [row_w-1:0]            out_row,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam logic [row_w-1:0] last_row = row_w'(m_rows - 1);

  logic [m_rows*res_width-1:0] act_data;
  logic [m_rows*res_width-1:0] pend_data;
  logic                        act_vld;
  logic                        pend_vld;
  logic [row_w-1:0]            row_cnt;

  logic accept;
  logic pop;
  logic pop_last;

  assign in_ready  = !pend_vld;
  assign accept    = in_valid && in_ready;
  assign pop       = act_vld && out_ready;
  assign out_last  = (row_cnt == last_row);
  assign pop_last  = pop && out_last;
  assign out_valid = act_vld;
  assign out_row   = row_cnt;
  assign busy      = act_vld || pend_vld;

  always_comb begin
    out_data = '0;
    for (int r = 0; r < m_rows; r++) begin
      if (row_cnt == row_w'(r)) begin
        out_data = act_data[r*res_width +: res_width];
      end
    end
  end

  // A last-row pop refills the active slot from pending first, otherwise straight
  // from the input; accepts that don't coincide with one fill the first free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_data  <= '0;
      pend_data <= '0;
      act_vld   <= 1'b0;
      pend_vld  <= 1'b0;
      row_cnt   <= '0;
    end else begin
      if (pop_last) begin
        row_cnt <= '0;
        if (pend_vld) begin
          act_data <= pend_data;
          pend_vld <= 1'b0;
        end else if (accept) begin
          act_data <= in_data;
        end else begin
          act_vld <= 1'b0;
        end
      end else if (pop) begin
        row_cnt <= row_cnt + row_w'(1);
      end

      if (accept && !pop_last) begin
        if (!act_vld) begin
          act_data <= in_data;
          act_vld  <= 1'b1;
          row_cnt  <= '0;
        end else begin
          pend_data <= in_data;
          pend_vld  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/mvm_result_serializer.md
Name: mvm_result_serializer

Overview:
Downstream stage of the matrix-times-vector multiplier. Accepts one packed result word (all m_rows row dot-products side by side) per handshake and emits the rows one at a time on a valid/ready stream, tagged with row index and last flag. Holds one result word while a second waits in a pending buffer, so the multiplier is not stalled for the whole drain time.

Parameters:
data_width, 2, bit width of each matrix/vector element in the multiplier
n_columns, 2, number of elements per row (dot-product length)
m_rows, 2, number of rows per result word
res_width, 2*data_width+$clog2(n_columns)+1 (=6 at defaults), width of one row result
row_w, (m_rows>1 ? $clog2(m_rows) : 1), width of out_row

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-high reset
in_data  input  m_rows*res_width  packed row results; row r at bits [r*res_width +: res_width]
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle
out_data  output  res_width  current row result
out_row  output  row_w  index of current row
out_last  output  1  high when out_row == m_rows-1
out_valid  output  1  out_data/out_row/out_last valid
out_ready  input  1  consumer accepts current row
busy  output  1  active or pending word held

Behaviour:
- Storage: active register (act_data, act_vld, row counter) and pending register (pend_data, pend_vld).
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready = !pend_vld (register-derived, no combinational path from in_valid or out_ready).
- out_valid = act_vld; out_data = act_data row selected by counter; out_row = counter; out_last = (counter == m_rows-1); busy = act_vld || pend_vld.
- Reset (rst high at posedge): act_vld=0, pend_vld=0, counter=0, stored data cleared to 0; so out_valid=0, out_data=0, out_row=0, out_last=0 (m_rows>1), busy=0, in_ready=1. Reset mid-drain discards both words; no further rows emitted.
- Latency: word accepted at edge N into an empty block → out_valid=1 with row 0 in cycle after edge N. One row per cycle under continuous out_ready; a word drains in m_rows cycles.
- Pop of non-last row: counter++, act_data unchanged.
- Pop of last row: counter→0; if pend_vld: pend→active (act_vld stays 1, pend_vld→0); else if Accept same edge: in_data→active directly; else act_vld→0.
- Accept with active empty (and no last-row pop): in_data→active, counter=0.
- Accept with active full and not last-row-popping: in_data→pending.
- Accept with active full, last-row pop, pend_vld=0: in_data→active (not pending).
- Accept when pend_vld=1: impossible (in_ready=0); in_valid ignored.
- Stall: while out_valid && !out_ready, out_data, out_row, out_last held stable.
- Order: rows leave strictly 0..m_rows-1, words strictly in accept order; no drop, no duplication.
- m_rows=1: out_row constant 0, out_last=out_valid… out_last=1 whenever counter=0 (always), each pop completes a word.
- No arithmetic on data; bits passed unchanged, unsigned.

Test Plan:
- Single word, defaults: in_data={6'd9,6'd5}, out_ready=1 → cycle+1: out_data=5,row=0,last=0; cycle+2: out_data=9,row=1,last=1; cycle+3: out_valid=0, busy=0.
- Back-to-back: words A={3,1}, B={7,4}, C={2,6} offered every cycle, out_ready=1 → stream 1,3,4,7,6,2 with last on 2nd/4th/6th; in_ready drops to 0 exactly while pending full; no word lost.
- Backpressure: out_ready=0 for 5 cycles after word {9,5} → out_data=5,row=0 held stable; second word {1,2} accepted into pending, in_ready=0; third word blocked; release → 5,9,2,1.
- Simultaneous last-pop + accept with pending empty: word {1,2} on row 1 pop edge → next cycle out_data=2,row=0, pend_vld stays 0, in_ready=1.
- Reset mid-drain: assert rst while row 0 of {9,5} shown and pending holds {1,2} → next cycle out_valid=0, busy=0, in_ready=1; no 9/1/2 ever emitted.
- m_rows=4, res_width=6: word {4,3,2,1} → rows 1,2,3,4 with out_row 0..3, out_last only on 4.
